// File: rtl/stream_demultiplexer_if.sv
// Handshake bundle for the 1-to-n stream demultiplexer: one producer port, n packed consumer channels.
// The master side is the producer/consumer environment and the slave side is the demultiplexer.
interface stream_demultiplexer_if #(
  parameter int n = 4,
  parameter int m = 4
);
  localparam int SW = (n > 1) ? $clog2(n) : 1;

  logic [m-1:0]   in_data;
  logic [SW-1:0]  in_sel;
  logic           in_valid;
  logic           in_ready;
  logic [n*m-1:0] out;
  logic [n-1:0]   out_valid;
  logic [n-1:0]   out_ready;
  logic           drop;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out, out_valid, drop
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out, out_valid, drop
  );
endinterface

// File: rtl/stream_demultiplexer.sv
// Registered 1-to-n demultiplexer: each accepted word lands in the one-entry buffer of the channel
// named by in_sel; an out-of-range select is swallowed and flagged one cycle later on drop.
module stream_demultiplexer #(
  parameter int n = 4,
  parameter int m = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  stream_demultiplexer_if.slave  bus
);
  localparam int            SW    = (n > 1) ? $clog2(n) : 1;
  localparam logic [SW:0]   N_EXT = (SW+1)'(n);

  logic [n-1:0][m-1:0] data_q, data_d;
  logic [n-1:0]        full_q, full_d;
  logic                drop_q, drop_d;
  logic                sel_legal;
  logic                sel_full;
  logic                sel_rdy;
  logic                in_ready;
  logic                xfer;

  always_comb begin
    sel_legal = ({1'b0, bus.in_sel} < N_EXT);
    sel_full  = 1'b0;
    sel_rdy   = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (bus.in_sel == SW'(k)) begin
        sel_full = full_q[k];
        sel_rdy  = bus.out_ready[k];
      end
    end

    // A draining channel frees its slot on the same edge, so it can take a new word right away.
    in_ready = !sel_legal || !sel_full || sel_rdy;
    xfer     = bus.in_valid && in_ready;

    data_d = data_q;
    full_d = full_q & ~bus.out_ready;
    for (int k = 0; k < n; k++) begin
      if (xfer && (bus.in_sel == SW'(k))) begin
        data_d[k] = bus.in_data;
        full_d[k] = 1'b1;
      end
    end

    drop_d = xfer && !sel_legal;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = data_q;
  assign bus.out_valid = full_q;
  assign bus.drop      = drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= '0;
      drop_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      drop_q <= drop_d;
    end
  end
endmodule
